button_conditioner: RTL

Front-end input stage that turns the raw, asynchronous push-button lines (btnC, btnU, btnL, btnR, btnD) into clean, clock-domain-safe signals for the top-level task FSM. Each button gets:
- a 2-flop synchronizer;
- a debounce filter;
- a debounced level;
- single-cycle press and release pulses;
- a single-cycle long-press pulse.

It replaces the bare synchronize-and-edge-detect logic in the top level. The top-level FSM consumes `btn_press` for transitions and `btn_level` for chord checks, for example "U pressed while C held".

---
 rtl/button_conditioner.sv | 92 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-bit 2-flop synchronizer, debounce filter, registered level,
// press/release pulses and a once-per-press long-hold pulse.
module button_conditioner #(
   parameter int unsigned N_BTN           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      logic [DbW-1:0]   db_cnt_q, db_cnt_d;
      logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             long_q, long_d;

      always_comb begin
         s1_d       = btn_in[i];
         s2_d       = s1_q;
         level_d    = level_q;
         press_d    = 1'b0;
         rel_d      = 1'b0;
         db_cnt_d   = db_cnt_q;
         hold_cnt_d = hold_cnt_q;

         // Any sample agreeing with the current level restarts the debounce window.
         if (s2_q == level_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DbLast) begin
            level_d  = s2_q;
            press_d  = s2_q;
            rel_d    = ~s2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end

         // Saturating at LONG_CYCLES keeps the long pulse to once per press.
         long_d = level_q && (hold_cnt_q == HoldLast);
         if (!level_q) begin
            hold_cnt_d = '0;
         end else if (hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
         end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
      assign btn_long[i]    = long_q;
   end

endmodule
